prover_beta_accum_interp: RTL and testbench



---
 rtl/prover_field_pkg.sv | 40 ++++
 rtl/prover_lane_addtree.sv | 40 ++++
 rtl/prover_beta_accum_interp.sv | 174 +++++++++++++++++
 tb/tb_prover_beta_accum_interp.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prover_field_pkg.sv
// rtl/prover_field_pkg.sv - field constants, FSM state type and mod-F_Q helpers for the beta accumulator
package prover_field_pkg;

    localparam int               F_NBITS = 16;
    localparam logic [F_NBITS-1:0] F_Q     = 16'd65521;
    localparam logic [F_NBITS-1:0] F_M1    = 16'd65520;
    localparam logic [F_NBITS-1:0] F_HALF  = 16'd32761;
    localparam logic [F_NBITS-1:0] F_SIXTH = 16'd54601;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_INTERP1,
        S_INTERP2,
        S_INTERP3,
        S_DONE
    } state_e;

    function automatic logic [F_NBITS-1:0] fadd(input logic [F_NBITS-1:0] a,
                                                input logic [F_NBITS-1:0] b);
        logic [F_NBITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, F_M1}) s = s - {1'b0, F_Q};
        return s[F_NBITS-1:0];
    endfunction

    function automatic logic [F_NBITS-1:0] fsub(input logic [F_NBITS-1:0] a,
                                                input logic [F_NBITS-1:0] b);
        return (a >= b) ? a - b : F_NBITS'({1'b0, a} + {1'b0, F_Q} - {1'b0, b});
    endfunction

    function automatic logic [F_NBITS-1:0] fmul(input logic [F_NBITS-1:0] a,
                                                input logic [F_NBITS-1:0] b);
        logic [2*F_NBITS-1:0] p;
        p = {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};
        return F_NBITS'(p % {{F_NBITS{1'b0}}, F_Q});
    endfunction

endpackage

// File: rtl/prover_lane_addtree.sv
// rtl/prover_lane_addtree.sv - registered mod-F_Q binary adder tree across nLanes values
module prover_lane_addtree
    import prover_field_pkg::*;
#(
    parameter int nLanes = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en_i,
    input  logic [nLanes-1:0][F_NBITS-1:0] lanes_i,
    output logic [F_NBITS-1:0]             sum_o
);

    localparam int LVLS = $clog2(nLanes);

    logic [F_NBITS-1:0] sum_q;

    // Each level halves the lane count; separate per-level nets keep the tree acyclic.
    for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
        logic [(nLanes >> l)-1:0][F_NBITS-1:0] node;
        if (l == 0) begin : g_leaf
            assign node = lanes_i;
        end else begin : g_sum
            for (genvar i = 0; i < (nLanes >> l); i++) begin : g_add
                assign node[i] = fadd(g_lvl[l-1].node[2*i], g_lvl[l-1].node[2*i+1]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else if (en_i) begin
            sum_q <= g_lvl[LVLS].node[0];
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/prover_beta_accum_interp.sv
// rtl/prover_beta_accum_interp.sv - sumcheck V-round beta accumulator and interpolator; option PROVER_BETA_ACCUM_ROUNDCNT_EN
module prover_beta_accum_interp
    import prover_field_pkg::*;
#(
    parameter int nLanes  = 8,
    parameter int nPoints = 4
`ifdef PROVER_BETA_ACCUM_ROUNDCNT_EN
    ,
    parameter int nRounds = 2
`endif
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic                                        in_last,
    input  logic [nLanes-1:0][nPoints-1:0][F_NBITS-1:0] v_in,
    input  logic [nLanes-1:0][nPoints-1:0][F_NBITS-1:0] beta_in,
    output logic [3:0][F_NBITS-1:0]                     c_out,
    output logic                                        out_ready,
    output logic                                        out_ready_pulse
`ifdef PROVER_BETA_ACCUM_ROUNDCNT_EN
    ,
    output logic                                        count_err
`endif
);

    state_e state_q;
    logic   in_ready_q, out_ready_q, pulse_q;
    logic   s1_v_q, s2_v_q;
    logic   accept, last_beat;

    logic [nPoints-1:0][nLanes-1:0][F_NBITS-1:0] prod_d, prod_q;
    logic [nPoints-1:0][F_NBITS-1:0]             pt_sum, acc_d, acc_q;
    logic [3:0][F_NBITS-1:0]                     c_out_q;
    logic [F_NBITS-1:0]                          c0_q, c2_q, c3_q, d_q;
    logic [F_NBITS-1:0]                          c2_d, d_d, c3_d, c1_d;

    // start always wins over a same-cycle beat
    assign accept = in_valid && in_ready_q && !start;

`ifdef PROVER_BETA_ACCUM_ROUNDCNT_EN
    localparam int CNT_W = $clog2(nRounds + 1);
    logic [CNT_W-1:0] cnt_q, cnt_inc;
    logic             err_q;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign last_beat = in_last || (cnt_inc == CNT_W'(nRounds));
    assign count_err = err_q;
`else
    assign last_beat = in_last;
`endif

    for (genvar p = 0; p < nPoints; p++) begin : g_point
        for (genvar l = 0; l < nLanes; l++) begin : g_lane
            assign prod_d[p][l] = fmul(v_in[l][p], beta_in[l][p]);
        end

        prover_lane_addtree #(.nLanes(nLanes)) u_tree (
            .clk     (clk),
            .rst     (rst),
            .en_i    (s1_v_q),
            .lanes_i (prod_q[p]),
            .sum_o   (pt_sum[p])
        );

        assign acc_d[p] = fadd(acc_q[p], pt_sum[p]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            s1_v_q <= accept;
            s2_v_q <= s1_v_q && !start;
            if (accept) prod_q <= prod_d;
            if (start) begin
                acc_q <= '0;
            end else if (s2_v_q) begin
                acc_q <= acc_d;
            end
        end
    end

    // e0=acc[0], e1=acc[1], e(-1)=acc[2], e2=acc[3]
    assign c2_d = fsub(fmul(fadd(acc_q[1], acc_q[2]), F_HALF), acc_q[0]);
    assign d_d  = fmul(fsub(acc_q[1], acc_q[2]), F_HALF);
    assign c1_d = fsub(d_q, c3_q);

    if (nPoints == 4) begin : g_cubic
        logic [F_NBITS-1:0] c2x2;
        assign c2x2 = fadd(c2_q, c2_q);
        assign c3_d = fmul(fsub(fsub(fsub(acc_q[3], acc_q[0]), fadd(c2x2, c2x2)),
                                fadd(d_q, d_q)), F_SIXTH);
    end else begin : g_quad
        assign c3_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            out_ready_q <= 1'b1;
            pulse_q     <= 1'b0;
            c_out_q     <= '0;
            c0_q        <= '0;
            c2_q        <= '0;
            c3_q        <= '0;
            d_q         <= '0;
`ifdef PROVER_BETA_ACCUM_ROUNDCNT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            pulse_q <= 1'b0;
            if (start) begin
                state_q     <= S_ACCUM;
                in_ready_q  <= 1'b1;
                out_ready_q <= 1'b0;
`ifdef PROVER_BETA_ACCUM_ROUNDCNT_EN
                cnt_q       <= '0;
                err_q       <= 1'b0;
`endif
            end else begin
                case (state_q)
                    S_ACCUM: begin
                        if (accept) begin
`ifdef PROVER_BETA_ACCUM_ROUNDCNT_EN
                            cnt_q <= cnt_inc;
`endif
                            if (last_beat) begin
                                state_q    <= S_DRAIN;
                                in_ready_q <= 1'b0;
`ifdef PROVER_BETA_ACCUM_ROUNDCNT_EN
                                err_q      <= !(in_last && (cnt_inc == CNT_W'(nRounds)));
`endif
                            end
                        end
                    end
                    // once S1 is empty, S2 commits the final sum into acc on this same edge
                    S_DRAIN: begin
                        if (!s1_v_q) state_q <= S_INTERP1;
                    end
                    S_INTERP1: begin
                        c0_q    <= acc_q[0];
                        c2_q    <= c2_d;
                        d_q     <= d_d;
                        state_q <= S_INTERP2;
                    end
                    S_INTERP2: begin
                        c3_q    <= c3_d;
                        state_q <= S_INTERP3;
                    end
                    S_INTERP3: begin
                        c_out_q     <= {c3_q, c2_q, c1_d, c0_q};
                        out_ready_q <= 1'b1;
                        pulse_q     <= 1'b1;
                        state_q     <= S_DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready        = in_ready_q;
    assign out_ready       = out_ready_q;
    assign out_ready_pulse = pulse_q;
    assign c_out           = c_out_q;

endmodule

// File: tb/tb_prover_beta_accum_interp.sv
// tb/tb_prover_beta_accum_interp.sv - directed self-checking bench for prover_beta_accum_interp
module tb_prover_beta_accum_interp;

    localparam int          NL  = 8;
    localparam longint      Q   = 65521;
    localparam logic [15:0] FM1 = 16'd65520;

    typedef logic [NL-1:0][3:0][15:0] beat4_t;
    typedef logic [NL-1:0][2:0][15:0] beat3_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic             start4 = 1'b0, valid4 = 1'b0, last4 = 1'b0;
    logic             ready4, ordy4, opulse4;
    beat4_t           v4 = '0, b4 = '0;
    logic [3:0][15:0] c_out4;

    logic             start3 = 1'b0, valid3 = 1'b0, last3 = 1'b0;
    logic             ready3, ordy3, opulse3;
    beat3_t           v3 = '0, b3 = '0;
    logic [3:0][15:0] c_out3;

`ifdef PROVER_BETA_ACCUM_ROUNDCNT_EN
    logic err4, err3;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    prover_beta_accum_interp #(.nLanes(NL), .nPoints(4)) dut4 (
        .clk             (clk),
        .rst             (rst),
        .start           (start4),
        .in_valid        (valid4),
        .in_ready        (ready4),
        .in_last         (last4),
        .v_in            (v4),
        .beta_in         (b4),
        .c_out           (c_out4),
        .out_ready       (ordy4),
        .out_ready_pulse (opulse4)
`ifdef PROVER_BETA_ACCUM_ROUNDCNT_EN
        ,
        .count_err       (err4)
`endif
    );

    prover_beta_accum_interp #(.nLanes(NL), .nPoints(3)) dut3 (
        .clk             (clk),
        .rst             (rst),
        .start           (start3),
        .in_valid        (valid3),
        .in_ready        (ready3),
        .in_last         (last3),
        .v_in            (v3),
        .beta_in         (b3),
        .c_out           (c_out3),
        .out_ready       (ordy3),
        .out_ready_pulse (opulse3)
`ifdef PROVER_BETA_ACCUM_ROUNDCNT_EN
        ,
        .count_err       (err3)
`endif
    );

    initial begin
        #400000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic beat4_t fill4(input logic [15:0] val);
        beat4_t r;
        for (int l = 0; l < NL; l++)
            for (int p = 0; p < 4; p++) r[l][p] = val;
        return r;
    endfunction

    function automatic longint eval_at(input logic [3:0][15:0] c, input longint x);
        longint r;
        r = 0;
        for (int i = 3; i >= 0; i--) r = (r * x + longint'(c[i])) % Q;
        return r;
    endfunction

    task automatic send4(input beat4_t v, input beat4_t b, input logic last);
        int n;
        n = 0;
        while (!ready4 && n < 20) begin
            step();
            n++;
        end
        n_cmp++;
        if (ready4 !== 1'b1) begin
            $display("FAIL send_in_ready actual=%0b required=1", ready4);
            n_bad++;
        end
        v4 = v; b4 = b; last4 = last; valid4 = 1'b1;
        step();
        valid4 = 1'b0; last4 = 1'b0;
    endtask

    task automatic wait_pulse4(input string name);
        int n;
        n = 0;
        while (!opulse4 && n < 30) begin
            step();
            n++;
        end
        n_cmp++;
        if (opulse4 !== 1'b1) begin
            $display("FAIL %s_done_timeout actual=%0b required=1", name, opulse4);
            n_bad++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_cmp++;
        if (ready4 !== 1'b0) begin $display("FAIL reset_in_ready actual=%0b required=0", ready4); n_bad++; end
        n_cmp++;
        if (ordy4 !== 1'b1 || ordy3 !== 1'b1) begin
            $display("FAIL reset_out_ready actual=%0b/%0b required=1/1", ordy4, ordy3); n_bad++;
        end
        n_cmp++;
        if (opulse4 !== 1'b0) begin $display("FAIL reset_pulse actual=%0b required=0", opulse4); n_bad++; end
        n_cmp++;
        if (c_out4 !== '0) begin $display("FAIL reset_c_out actual=%h required=0", c_out4); n_bad++; end
`ifdef PROVER_BETA_ACCUM_ROUNDCNT_EN
        n_cmp++;
        if (err4 !== 1'b0 || err3 !== 1'b0) begin
            $display("FAIL reset_count_err actual=%0b/%0b required=0/0", err4, err3); n_bad++;
        end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_beat();
        logic [3:0][15:0] exp_c;
        beat4_t ones;
        ones = fill4(16'd1);
        start4 = 1'b1; step(); start4 = 1'b0;
        n_cmp++;
        if (ordy4 !== 1'b0) begin $display("FAIL accum_out_ready actual=%0b required=0", ordy4); n_bad++; end
        send4(ones, ones, 1'b1);
        repeat (4) step();
        n_cmp++;
        if (opulse4 !== 1'b0 || ordy4 !== 1'b0) begin
            $display("FAIL single_early actual=pulse %0b rdy %0b required=0 0", opulse4, ordy4); n_bad++;
        end
        step();
        n_cmp++;
        if (opulse4 !== 1'b1) begin $display("FAIL single_pulse_latency actual=%0b required=1", opulse4); n_bad++; end
        exp_c = {16'd0, 16'd0, 16'd0, 16'd8};
        n_cmp++;
        if (c_out4 !== exp_c) begin $display("FAIL single_c_out actual=%h required=%h", c_out4, exp_c); n_bad++; end
        step();
        n_cmp++;
        if (opulse4 !== 1'b0 || ordy4 !== 1'b1) begin
            $display("FAIL single_pulse_width actual=pulse %0b rdy %0b required=0 1", opulse4, ordy4); n_bad++;
        end
    endtask

    task automatic test_x_cubed();
        logic [3:0][15:0] exp_c;
        beat4_t v;
        v = '0;
        v[0][1] = 16'd1;
        v[0][2] = FM1;
        v[0][3] = 16'd8;
        start4 = 1'b1; step(); start4 = 1'b0;
        send4(v, fill4(16'd1), 1'b1);
        wait_pulse4("x_cubed");
        exp_c = {16'd1, 16'd0, 16'd0, 16'd0};
        n_cmp++;
        if (c_out4 !== exp_c) begin $display("FAIL x_cubed_c_out actual=%h required=%h", c_out4, exp_c); n_bad++; end
    endtask

    task automatic test_three_point();
        logic [3:0][15:0] exp_c;
        int n;
        v3 = '0;
        v3[0][0] = 16'd1;
        v3[0][1] = 16'd6;
        v3[0][2] = 16'd2;
        for (int l = 0; l < NL; l++)
            for (int p = 0; p < 3; p++) b3[l][p] = 16'd1;
        start3 = 1'b1; step(); start3 = 1'b0;
        n_cmp++;
        if (ready3 !== 1'b1) begin $display("FAIL three_in_ready actual=%0b required=1", ready3); n_bad++; end
        valid3 = 1'b1; last3 = 1'b1;
        step();
        valid3 = 1'b0; last3 = 1'b0;
        n = 0;
        while (!opulse3 && n < 30) begin
            step();
            n++;
        end
        n_cmp++;
        if (opulse3 !== 1'b1) begin $display("FAIL three_done_timeout actual=%0b required=1", opulse3); n_bad++; end
        exp_c = {16'd0, 16'd3, 16'd2, 16'd1};
        n_cmp++;
        if (c_out3 !== exp_c) begin $display("FAIL three_c_out actual=%h required=%h", c_out3, exp_c); n_bad++; end
    endtask

    task automatic run_random(input int nbeats, input string name);
        beat4_t v, b;
        longint e [4];
        longint xs [4];
        longint got;
        xs = '{0, 1, Q - 1, 2};
        for (int p = 0; p < 4; p++) e[p] = 0;
        start4 = 1'b1; step(); start4 = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            for (int l = 0; l < NL; l++)
                for (int p = 0; p < 4; p++) begin
                    v[l][p] = 16'($urandom_range(0, 65520));
                    b[l][p] = 16'($urandom_range(0, 65520));
                    e[p] = (e[p] + longint'(v[l][p]) * longint'(b[l][p])) % Q;
                end
            send4(v, b, k == nbeats - 1);
        end
        wait_pulse4(name);
        for (int i = 0; i < 4; i++) begin
            got = eval_at(c_out4, xs[i]);
            n_cmp++;
            if (got !== e[i]) begin
                $display("FAIL %s_eval%0d actual=%0d required=%0d", name, i, got, e[i]); n_bad++;
            end
        end
    endtask

    task automatic test_back_to_back();
        run_random(2, "b2b_two_beats");
        run_random(1, "b2b_run1");
        run_random(2, "b2b_run2");
        run_random(1, "b2b_run3");
    endtask

    task automatic test_abort();
        logic [3:0][15:0] exp_c;
        beat4_t junk;
        junk = fill4(16'd777);
        start4 = 1'b1; step(); start4 = 1'b0;
        send4(junk, junk, 1'b0);
        start4 = 1'b1; valid4 = 1'b1; last4 = 1'b1; v4 = fill4(16'd4321);
        step();
        start4 = 1'b0; valid4 = 1'b0; last4 = 1'b0;
        send4(fill4(16'd1), fill4(16'd1), 1'b1);
        wait_pulse4("abort");
        exp_c = {16'd0, 16'd0, 16'd0, 16'd8};
        n_cmp++;
        if (c_out4 !== exp_c) begin $display("FAIL abort_c_out actual=%h required=%h", c_out4, exp_c); n_bad++; end
    endtask

    task automatic test_reset_mid_interp();
        int seen;
        start4 = 1'b1; step(); start4 = 1'b0;
        send4(fill4(16'd2), fill4(16'd3), 1'b1);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (ready4 !== 1'b0 || ordy4 !== 1'b1 || opulse4 !== 1'b0) begin
            $display("FAIL rst_mid_ctrl actual=%0b%0b%0b required=010", ready4, ordy4, opulse4); n_bad++;
        end
        n_cmp++;
        if (c_out4 !== '0) begin $display("FAIL rst_mid_c_out actual=%h required=0", c_out4); n_bad++; end
        seen = 0;
        repeat (8) begin
            step();
            if (opulse4) seen++;
        end
        n_cmp++;
        if (seen != 0) begin $display("FAIL rst_mid_late_pulse actual=%0d required=0", seen); n_bad++; end
    endtask

`ifdef PROVER_BETA_ACCUM_ROUNDCNT_EN
    task automatic test_roundcnt();
        int acc_n;
        start4 = 1'b1; step(); start4 = 1'b0;
        send4(fill4(16'd1), fill4(16'd1), 1'b1);
        n_cmp++;
        if (err4 !== 1'b1) begin $display("FAIL cnt_early_last actual=%0b required=1", err4); n_bad++; end
        wait_pulse4("cnt_early");

        start4 = 1'b1; step(); start4 = 1'b0;
        n_cmp++;
        if (err4 !== 1'b0) begin $display("FAIL cnt_clear_on_start actual=%0b required=0", err4); n_bad++; end
        v4 = fill4(16'd1); b4 = fill4(16'd1); last4 = 1'b0; valid4 = 1'b1;
        acc_n = 0;
        repeat (5) begin
            if (ready4) acc_n++;
            step();
        end
        valid4 = 1'b0;
        n_cmp++;
        if (acc_n != 2) begin $display("FAIL cnt_accepted actual=%0d required=2", acc_n); n_bad++; end
        n_cmp++;
        if (err4 !== 1'b1) begin $display("FAIL cnt_no_last actual=%0b required=1", err4); n_bad++; end
        wait_pulse4("cnt_forced");

        start4 = 1'b1; step(); start4 = 1'b0;
        send4(fill4(16'd1), fill4(16'd1), 1'b0);
        send4(fill4(16'd1), fill4(16'd1), 1'b1);
        n_cmp++;
        if (err4 !== 1'b0) begin $display("FAIL cnt_good_run actual=%0b required=0", err4); n_bad++; end
        wait_pulse4("cnt_good");
    endtask
`endif

    initial begin
        test_reset();
        test_single_beat();
        test_x_cubed();
        test_three_point();
        test_back_to_back();
        test_abort();
        test_reset_mid_interp();
`ifdef PROVER_BETA_ACCUM_ROUNDCNT_EN
        test_roundcnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
